// File: rtl/seg7_serial_driver_pkg.sv
// seg7_serial_driver_pkg: FSM state codes, segment constants and the hex-to-segment encoder
package seg7_serial_driver_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;
  localparam int SEG_DP = 7;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    case (n)
      4'h0: hex2seg = 7'h3F;
      4'h1: hex2seg = 7'h06;
      4'h2: hex2seg = 7'h5B;
      4'h3: hex2seg = 7'h4F;
      4'h4: hex2seg = 7'h66;
      4'h5: hex2seg = 7'h6D;
      4'h6: hex2seg = 7'h7D;
      4'h7: hex2seg = 7'h07;
      4'h8: hex2seg = 7'h7F;
      4'h9: hex2seg = 7'h6F;
      4'hA: hex2seg = 7'h77;
      4'hB: hex2seg = 7'h7C;
      4'hC: hex2seg = 7'h39;
      4'hD: hex2seg = 7'h5E;
      4'hE: hex2seg = 7'h79;
      default: hex2seg = 7'h71;
    endcase
  endfunction
endpackage

// File: rtl/seg7_serial_driver_if.sv
// seg7_serial_driver_if: host-side request/status bundle for the 7-segment serial driver
interface seg7_serial_driver_if #(parameter int NUM_DIGITS = 8);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0] dots;
  logic [NUM_DIGITS-1:0] blank;
  logic lz_en;
  logic raw_mode;
  logic [8*NUM_DIGITS-1:0] raw_seg;
  logic update;
  logic busy;
  logic done;
  modport master(output value, dots, blank, lz_en, raw_mode, raw_seg, update, input busy, done);
  modport slave(input value, dots, blank, lz_en, raw_mode, raw_seg, update, output busy, done);
endinterface

// File: rtl/seg7_serial_driver_encode.sv
// seg7_serial_driver_encode: one digit's segment byte after blank/raw/encode precedence and polarity
module seg7_serial_driver_encode
  import seg7_serial_driver_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dot,
  input  logic       blank,
  input  logic       raw,
  input  logic [7:0] raw_byte,
  input  logic       lz_kill,
  output logic [7:0] seg
);
  logic [7:0] hi;
  always_comb begin
    hi = (blank || lz_kill) ? SEG_BLANK : raw ? raw_byte : (8'(hex2seg(nibble)) | (8'(dot) << SEG_DP));
    seg = SEG_ACTIVE_LOW ? ~hi : hi;
  end
endmodule

// File: rtl/seg7_serial_driver.sv
// seg7_serial_driver: snapshots a hex value, encodes it per digit and shifts the frame
// out to a serial shift-register display, with auto-refresh and an update handshake.
module seg7_serial_driver
  import seg7_serial_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCLK_DIV       = 2,
  parameter int REFRESH_CYCLES = 65536,
  parameter bit MSB_FIRST      = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  seg7_serial_driver_if.slave host,
  output logic seg_clk,
  output logic seg_clrn,
  output logic seg_dt,
  output logic seg_en
);
  localparam int FW = 8*NUM_DIGITS;
  localparam int RW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DW = $clog2(2*SCLK_DIV);
  localparam int BW = $clog2(FW);
  localparam logic [RW-1:0] REF_TOP = RW'(REFRESH_CYCLES > 0 ? REFRESH_CYCLES-1 : 0);
  logic [1:0] state_q, state_d;
  logic pending_q, pending_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [FW-1:0] frame_q, frame_d, frame_new;
  logic clrn_q;
  logic [NUM_DIGITS-1:0] kill;
  logic run, tick, req, div_end, last_bit;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [7:0] seg;
    seg7_serial_driver_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc (
      .nibble(host.value[4*i+:4]),
      .dot(host.dots[i]),
      .blank(host.blank[i]),
      .raw(host.raw_mode),
      .raw_byte(host.raw_seg[8*i+:8]),
      .lz_kill(kill[i]),
      .seg(seg)
    );
    // The frame always shifts out from its top bit, so bit order is fixed here.
    for (genvar b = 0; b < 8; b++) begin : g_bit
      assign frame_new[8*i+b] = MSB_FIRST ? seg[b] : seg[7-b];
    end
  end
  always_comb begin
    kill = '0;
    run = host.lz_en && !host.raw_mode;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      run = run && host.value[4*i+:4] == 4'h0 && !host.dots[i];
      kill[i] = run;
    end
  end
  assign tick = REFRESH_CYCLES != 0 && ref_q == REF_TOP;
  assign req = host.update || tick;
  assign div_end = div_q == DW'(2*SCLK_DIV-1);
  assign last_bit = bit_q == BW'(FW-1);
  always_comb begin
    ref_d = (REFRESH_CYCLES == 0 || tick) ? '0 : ref_q + 1'b1;
    state_d = state_q;
    pending_d = pending_q || req;
    div_d = '0;
    bit_d = bit_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        state_d = pending_d ? S_LOAD : S_IDLE;
        pending_d = 1'b0;
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        frame_d = frame_new;
        bit_d = '0;
      end
      S_SHIFT: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        frame_d = div_end ? frame_q << 1 : frame_q;
        bit_d = div_end ? bit_q + 1'b1 : bit_q;
        state_d = (div_end && last_bit) ? S_LATCH : S_SHIFT;
      end
      default: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        state_d = !div_end ? S_LATCH : pending_d ? S_LOAD : S_IDLE;
        pending_d = pending_d && !div_end;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pending_q <= 1'b0;
      ref_q <= '0;
      div_q <= '0;
      bit_q <= '0;
      frame_q <= '0;
      clrn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      ref_q <= ref_d;
      div_q <= div_d;
      bit_q <= bit_d;
      frame_q <= frame_d;
      clrn_q <= 1'b1;
    end
  end
  assign seg_clk = state_q == S_SHIFT && div_q >= DW'(SCLK_DIV);
  assign seg_dt = state_q == S_SHIFT && frame_q[FW-1];
  assign seg_en = state_q == S_LATCH;
  assign seg_clrn = clrn_q;
  assign host.busy = state_q != S_IDLE;
  assign host.done = state_q == S_LATCH && div_end;
endmodule

// File: tb/tb_seg7_serial_driver.sv
// tb_seg7_serial_driver: scoreboard bench; expected bytes are queued at update time and
// compared as the serial stream is deserialised from seg_clk/seg_dt.
module tb_seg7_serial_driver;
  localparam int N = 8;
  localparam logic [6:0] HEX_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic clk0, clrn0, dt0, en0, clk1, clrn1, dt1, en1;
  always #5 clk = ~clk;
  seg7_serial_driver_if #(.NUM_DIGITS(N)) h0 ();
  seg7_serial_driver_if #(.NUM_DIGITS(N)) h1 ();
  seg7_serial_driver #(.NUM_DIGITS(N), .SCLK_DIV(2), .REFRESH_CYCLES(0), .MSB_FIRST(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .host(h0), .seg_clk(clk0), .seg_clrn(clrn0), .seg_dt(dt0), .seg_en(en0));
  seg7_serial_driver #(.NUM_DIGITS(N), .SCLK_DIV(2), .REFRESH_CYCLES(1000), .MSB_FIRST(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_ref (
    .clk(clk), .rst_n(rst_n), .host(h1), .seg_clk(clk1), .seg_clrn(clrn1), .seg_dt(dt1), .seg_en(en1));

  logic prev_clk0 = 1'b0;
  int nbits = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] want;
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0;
      prev_clk0 = 1'b0;
    end else begin
      if (clk0 && !prev_clk0) begin
        sh = {sh[6:0], dt0};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL byte_unexpected got=%h required=no byte", sh);
          end else begin
            want = exp_q.pop_front();
            if (sh !== want) begin
              failures++;
              $display("FAIL frame_byte got=%h required=%h", sh, want);
            end
          end
        end
      end
      prev_clk0 = clk0;
    end
  end

  task automatic push_frame(input logic [31:0] v, input logic [7:0] d, input logic [7:0] bl,
                            input logic lz, input logic raw, input logic [63:0] rs);
    logic run;
    logic [3:0] nb;
    logic [7:0] b;
    run = lz && !raw;
    for (int i = N-1; i >= 0; i--) begin
      nb = v[4*i+:4];
      run = run && i > 0 && nb == 4'h0 && !d[i];
      if (bl[i] || run) b = 8'h00;
      else if (raw) b = rs[8*i+:8];
      else b = {d[i], HEX_TAB[nb]};
      exp_q.push_back(~b);
    end
  endtask

  task automatic send(input logic [31:0] v, input logic [7:0] d, input logic [7:0] bl,
                      input logic lz, input logic raw, input logic [63:0] rs);
    @(negedge clk);
    h0.value = v; h0.dots = d; h0.blank = bl; h0.lz_en = lz; h0.raw_mode = raw; h0.raw_seg = rs;
    h0.update = 1'b1;
    push_frame(v, d, bl, lz, raw, rs);
    @(negedge clk);
    h0.update = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (!h0.done && k < 2000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic finish_frame(input string name);
    int k;
    wait_done(k);
    checks++;
    if (k !== 261) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=261", name, k);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL %s_bytes_left got=%0d required=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({clk0, clrn0, dt0, en0, h0.busy, h0.done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=000000", {clk0, clrn0, dt0, en0, h0.busy, h0.done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (clrn0 !== 1'b1) begin
      failures++;
      $display("FAIL clrn_release got=%b required=1", clrn0);
    end
  endtask

  task automatic test_idle();
    int act = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (clk0 || en0 || h0.busy) act++;
    end
    checks++;
    if (act !== 0) begin
      failures++;
      $display("FAIL idle_activity got=%0d required=0", act);
    end
  endtask

  task automatic test_digits();
    send(32'h12345678, 8'h00, 8'h00, 1'b0, 1'b0, 64'h0);
    finish_frame("digits");
    send(32'h9ABCDEF0, 8'h81, 8'h00, 1'b0, 1'b0, 64'h0);
    finish_frame("digits_dots");
  endtask

  task automatic test_lz();
    send(32'h00000A05, 8'h00, 8'h00, 1'b1, 1'b0, 64'h0);
    finish_frame("lz_a05");
    send(32'h00000000, 8'h00, 8'h00, 1'b1, 1'b0, 64'h0);
    finish_frame("lz_zero");
    send(32'h00000000, 8'h20, 8'h00, 1'b1, 1'b0, 64'h0);
    finish_frame("lz_dot5");
  endtask

  task automatic test_raw_blank();
    send(32'h00000000, 8'h00, 8'h08, 1'b1, 1'b1, 64'h0123456789ABCDEF);
    finish_frame("raw_blank");
    send(32'h87654321, 8'hFF, 8'h81, 1'b0, 1'b0, 64'h0);
    finish_frame("blank_dots");
  endtask

  task automatic test_back_to_back();
    int dq [$];
    h0.value = 32'h11111111; h0.dots = 8'h00; h0.blank = 8'h00; h0.lz_en = 1'b0; h0.raw_mode = 1'b0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (h0.done) dq.push_back(c);
      h0.update = (c == 0 || c == 50 || c == 100);
      if (c == 0) push_frame(32'h11111111, 8'h00, 8'h00, 1'b0, 1'b0, 64'h0);
      if (c == 60) begin
        h0.value = 32'hCAFE0042;
        push_frame(32'hCAFE0042, 8'h00, 8'h00, 1'b0, 1'b0, 64'h0);
      end
    end
    h0.update = 1'b0;
    checks++;
    if (dq.size() !== 2) begin
      failures++;
      $display("FAIL b2b_frames got=%0d required=2", dq.size());
    end else begin
      checks++;
      if (dq[0] !== 261 || dq[1] !== 522) begin
        failures++;
        $display("FAIL b2b_done_times got=%0d,%0d required=261,522", dq[0], dq[1]);
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_bytes_left got=%0d required=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_and_refresh();
    int dq [$];
    int act = 0;
    send(32'h13572468, 8'h00, 8'h00, 1'b0, 1'b0, 64'h0);
    repeat (82) @(negedge clk);
    checks++;
    if (!(h0.busy && !en0)) begin
      failures++;
      $display("FAIL mid_in_shift got busy=%b en=%b required busy=1 en=0", h0.busy, en0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clk0, clrn0, dt0, en0, h0.busy, h0.done} !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b required=000000", {clk0, clrn0, dt0, en0, h0.busy, h0.done});
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3500; c++) begin
      @(negedge clk);
      if (h0.busy) act++;
      if (h1.done) dq.push_back(c);
    end
    checks++;
    if (act !== 0) begin
      failures++;
      $display("FAIL mid_reset_dropped got=%0d busy cycles required=0", act);
    end
    checks++;
    if (dq.size() !== 3) begin
      failures++;
      $display("FAIL refresh_count got=%0d required=3", dq.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (dq[i] - dq[i-1] !== 1000) begin
          failures++;
          $display("FAIL refresh_spacing got=%0d required=1000", dq[i] - dq[i-1]);
        end
      end
    end
  endtask

  initial begin
    h0.value = '0; h0.dots = '0; h0.blank = '0; h0.lz_en = 1'b0; h0.raw_mode = 1'b0; h0.raw_seg = '0; h0.update = 1'b0;
    h1.value = 32'h01234567; h1.dots = '0; h1.blank = '0; h1.lz_en = 1'b0; h1.raw_mode = 1'b0; h1.raw_seg = '0; h1.update = 1'b0;
    test_reset();
    test_idle();
    test_digits();
    test_lz();
    test_raw_blank();
    test_back_to_back();
    test_reset_mid_and_refresh();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
